// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V instruction front end.
// Word size, reset vector and instruction encoding helpers.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int INST_BYTES = 4;

    typedef logic [XLEN-1:0] xword_t;

    localparam xword_t RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle: memory request/response channel,
// instruction delivery handshake and redirect from the core.
interface inst_prefetch_queue_if #(
    parameter int XLEN = riscv_pkg::XLEN
);

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; DEPTH must be a power of 2
// so the read/write pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited fetch requests,
// in-order response buffering, and redirect flush with stale-drop.
module inst_prefetch_queue #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_prefetch_queue_if.master bus
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = CW + 2;
    localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] out_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic [UW-1:0]   used;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            rsp_any;
    logic            do_pop;
    logic [XLEN-1:0] target;

    // Every slot is either buffered, in flight or owed a drop.
    assign used = UW'(fifo_count) + UW'(inflight) + UW'(drop_cnt);

    assign bus.mem_req_valid = !bus.redirect_valid && (used < UW'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_drop = bus.mem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = bus.mem_rsp_valid && (drop_cnt == '0)
                   && (inflight != '0);
    assign rsp_any  = rsp_drop || rsp_keep;

    assign do_pop    = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign fifo_push = rsp_keep && !bus.redirect_valid;
    assign target    = bus.redirect_pc & ~XLEN'(3);

    assign bus.inst_valid = !fifo_empty;
    assign bus.inst_data  = fifo_empty ? XLEN'(NOP_INST) : fifo_head;
    assign bus.inst_pc    = out_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            out_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= target;
            out_pc   <= target;
            inflight <= '0;
            drop_cnt <= drop_cnt + inflight - CW'(rsp_any);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            if (do_pop) begin
                out_pc <= out_pc + STEP;
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_keep);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (fifo_push),
        .push_data (bus.mem_rsp_data),
        .pop       (do_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A response with nothing outstanding is a memory protocol error.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_rsp_valid && inflight == '0 && drop_cnt == '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !do_pop));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        used <= UW'(DEPTH));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench: memory model with variable latency, a
// request-tracking reference model, vector table and corner sequences.
module tb_inst_prefetch_queue;

    import riscv_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    inst_prefetch_queue_if #(.XLEN(XLEN)) bus ();

    inst_prefetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    mreq_t       mq[$];
    ent_t        fq[$];
    logic [31:0] fired[$];
    logic [31:0] popped[$];
    logic [31:0] m_fetch;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    bit          const_mode = 1'b0;
    logic        obs_req_valid;
    logic        obs_inst_valid;
    logic [31:0] obs_req_addr;
    logic [31:0] obs_inst_pc;
    logic [31:0] obs_inst_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_mode) return 32'hFFFF_F137;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        mq.delete();
        fq.delete();
        m_fetch = RESET_PC;
    endtask

    // One clock: drive inputs, compare against the model, advance it.
    task automatic cycle(input bit rdr, input logic [31:0] rpc,
                         input bit ir, input bit mr);
        bit    rv;
        bit    exp_req;
        bit    fire;
        bit    pop;
        mreq_t r;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.redirect_valid = rdr;
        bus.redirect_pc = rpc;
        bus.inst_ready = ir;
        bus.mem_req_ready = mr;
        bus.mem_rsp_valid = rv;
        bus.mem_rsp_data = rv ? mem_word(mq[0].addr) : 32'h0;
        #1;
        obs_req_valid = bus.mem_req_valid;
        obs_req_addr = bus.mem_req_addr;
        obs_inst_valid = bus.inst_valid;
        obs_inst_pc = bus.inst_pc;
        obs_inst_data = bus.inst_data;
        exp_req = !rdr && ((fq.size() + mq.size()) < DEPTH);
        chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", bus.mem_req_addr, m_fetch);
        chk("inst_valid", 32'(bus.inst_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            chk("inst_pc", bus.inst_pc, fq[0].pc);
            chk("inst_data", bus.inst_data, fq[0].data);
        end
        if (bus.mem_req_valid && mr) fired.push_back(bus.mem_req_addr);
        if (bus.inst_valid && ir && !rdr) popped.push_back(bus.inst_pc);
        pop = (fq.size() > 0) && ir && !rdr;
        fire = exp_req && mr;
        if (rv) r = mq.pop_front();
        if (rdr) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(fq.pop_front());
            if (rv && !r.stale) fq.push_back('{r.addr, mem_word(r.addr)});
            if (fire) begin
                mq.push_back('{m_fetch, cyc + lat, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   first;
        int   bubbles;
        int   ndrop;
        bit   got;

        vecs[0] = '{32'h0000_0203, 32'h0000_0200};
        vecs[1] = '{32'h0000_0100, 32'h0000_0100};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[3] = '{32'h0000_0007, 32'h0000_0004};
        vecs[4] = '{32'h8000_0002, 32'h8000_0000};

        // Streaming at full rate with a constant instruction word.
        const_mode = 1'b1;
        lat = 1;
        do_reset();
        fired.delete();
        first = -1;
        bubbles = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            if (obs_inst_valid && first < 0) begin
                first = i;
                chk("first_data", obs_inst_data, 32'hFFFF_F137);
                chk("first_pc", obs_inst_pc, 32'h0);
            end else if (!obs_inst_valid && first >= 0) begin
                bubbles++;
            end
        end
        chk("first_valid_cycle", 32'(first), 32'd2);
        chk("bubbles", 32'(bubbles), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < fired.size()) chk("stream_addr", fired[i], 32'(4 * i));
        end
        const_mode = 1'b0;

        // Consumer stalled: exactly DEPTH requests, then resume.
        do_reset();
        fired.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("stall_requests", 32'(fired.size()), 32'd4);
        chk("stall_req_valid", 32'(obs_req_valid), 32'd0);
        fired.delete();
        popped.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("release_pops_ge4", 32'(popped.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < popped.size()) chk("release_pc", popped[i], 32'(4 * i));
        end
        if (fired.size() > 0) chk("resume_addr", fired[0], 32'h10);
        else chk("resume_fired", 32'd0, 32'd1);

        // Redirect with two stale requests in flight.
        lat = 3;
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("inflight_before_redirect", 32'(dut.inflight), 32'd2);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            if (obs_inst_valid) begin
                got = 1'b1;
                chk("redir_pc", obs_inst_pc, 32'h100);
                chk("redir_data", obs_inst_data, mem_word(32'h100));
            end
        end
        chk("redir_inst_seen", 32'(got), 32'd1);

        // Vector table: redirect target alignment and first fetch.
        lat = 1;
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
            cycle(1'b1, vecs[v].rpc, 1'b1, 1'b1);
            chk("vec_req_low", 32'(obs_req_valid), 32'd0);
            cycle(1'b0, '0, 1'b1, 1'b1);
            chk("vec_req_valid", 32'(obs_req_valid), 32'd1);
            chk("vec_req_addr", obs_req_addr, vecs[v].exp_pc);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                cycle(1'b0, '0, 1'b1, 1'b1);
                if (obs_inst_valid) begin
                    got = 1'b1;
                    chk("vec_inst_pc", obs_inst_pc, vecs[v].exp_pc);
                end
            end
            chk("vec_inst_seen", 32'(got), 32'd1);
        end

        // Redirect coinciding with a response and a pop.
        lat = 2;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (mq.size() >= 2 && mq[0].due <= cyc && fq.size() > 0) got = 1'b1;
            else cycle(1'b0, '0, 1'b1, 1'b1);
        end
        chk("coincide_setup", 32'(got), 32'd1);
        ndrop = mq.size() - 1;
        popped.delete();
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        chk("coincide_drop_cnt", 32'(dut.drop_cnt), 32'(ndrop));
        chk("coincide_no_pop", 32'(popped.size()), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("coincide_empty", 32'(obs_inst_valid), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Reset while three instructions are buffered.
        lat = 1;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (fq.size() == 3) got = 1'b1;
            else cycle(1'b0, '0, 1'b0, 1'b1);
        end
        chk("buffer3_setup", 32'(got), 32'd1);
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("midrst_inst_valid", 32'(obs_inst_valid), 32'd0);
        chk("midrst_req_valid", 32'(obs_req_valid), 32'd1);
        chk("midrst_req_addr", obs_req_addr, RESET_PC);

        // Random traffic against the model, including wrap-around targets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          rdr;
            logic [31:0] rpc;
            lat = $urandom_range(1, 4);
            rdr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else rpc = $urandom();
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle(rdr, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the five-stage core.
- Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO.
- Delivers instruction + PC pairs to the core's IF stage over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the core, which flushes the queue and discards all in-flight responses.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, total slots: buffered + in-flight + pending-drop (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  word-aligned fetch address
mem_rsp_valid  input  1  response valid (in order, latency >=1 cycle)
mem_rsp_data  input  XLEN  instruction word
inst_valid  output  1  instruction available to core
inst_ready  input  1  core IF stage consumes
inst_data  output  XLEN  instruction word at FIFO head
inst_pc  output  XLEN  PC of inst_data
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (forced 0)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: mem_req_valid=0, inst_valid=0, fetch_pc=RESET_PC, out_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0.
- Counters:
  - fetch_pc: next request address.
  - out_pc: PC of the FIFO head.
  - inflight: accepted requests with no response yet.
  - drop_cnt: responses still to be discarded.
  - Width of each counter is $clog2(DEPTH+1).
- Credit rule: mem_req_valid = !redirect_valid && (fifo_count + inflight + drop_cnt < DEPTH); mem_req_addr = fetch_pc.
- Request handshake (valid && ready): fetch_pc += 4; inflight += 1.
- Response, drop_cnt>0: drop_cnt -= 1; data discarded.
- Response, drop_cnt==0: push {mem_rsp_data} into FIFO; inflight -= 1.
- The credit rule guarantees the FIFO never overflows. A response arriving with inflight==0 && drop_cnt==0 is a protocol error: ignore it and hold an assertion.
- inst_valid = FIFO not empty; inst_data = FIFO head; inst_pc = out_pc. Outputs are combinational from registers only (no input-to-output paths).
- Pop (inst_valid && inst_ready): FIFO head advances; out_pc += 4.
- Simultaneous push and pop in one cycle are both honoured; FIFO count is unchanged.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared.
  - fetch_pc <= out_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt <= drop_cnt + inflight - (mem_rsp_valid ? 1 : 0).
  - inflight <= 0.
  - A pop or push coinciding with the redirect has no effect.
  - mem_req_valid is low during the redirect cycle.
  - First new request is issued the cycle after the redirect.
- Latency:
  - After reset deassertion, mem_req_valid rises in the first cycle.
  - An instruction is visible on inst_valid 1 cycle after its response arrives.
- Wrap-around: fetch_pc and out_pc wrap modulo 2^XLEN without error.
- Back-to-back redirects: each cycle re-applies the redirect rule; only the last target is fetched.
- Reset mid-operation clears all state. Memory must share the same reset, so no stale responses are expected.

Decomposition:
- Shared package riscv_pkg:
  - XLEN.
  - RESET_PC.
  - INST_BYTES=4.
  - NOP_INST=32'h0000_0013 (addi x0,x0,0).
- One sub-module, sync_fifo:
  - Parameterised width/depth.
  - Synchronous flush input.
  - Exports count, full, empty.
- All counters and the credit/drop logic stay in inst_prefetch_queue.

Test Plan:
- Reset, then memory always ready with 1-cycle latency returning 32'hFFFFF137 (lui x2,0xfffff) -> requests at 0x0,0x4,0x8,0xC; inst_pc follows 0x0,0x4,... with inst_ready=1 and no bubbles after the first.
- Hold inst_ready=0 -> exactly DEPTH=4 requests issued, then mem_req_valid=0. Release ready -> 4 pops at PCs 0x0..0xC, then fetching resumes at 0x10.
- Memory latency 3, redirect_valid with redirect_pc=0x100 while 2 requests are in flight -> the 2 stale responses are dropped. First inst_valid shows inst_pc=0x100 with data from address 0x100.
- redirect_pc=0x203 -> mem_req_addr=0x200, inst_pc=0x200.
- Redirect in the same cycle as mem_rsp_valid and inst_ready -> no push, no pop; drop_cnt = inflight-1; queue empty the next cycle.
- Assert reset mid-stream with 3 entries buffered -> next cycle inst_valid=0, mem_req_valid=1, mem_req_addr=RESET_PC.
